ped_crossing_ctrl: RTL and testbench

Pedestrian-side controller for the crossing request/grant interface of the intersection. It debounces the raw push-button, raises and holds the `pedToggle` request toward the traffic-light state machine, and waits for that machine's `pedLight` grant. It then sequences the pedestrian signal head: steady WALK, then a flashing DON'T WALK with a numeric countdown, then steady DON'T WALK. It sits between the button/lamp hardware and the traffic-light state machine's `pedToggle`/`pedLight` ports.

---
 rtl/ped_crossing_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// ped_crossing_ctrl
//
// Pedestrian-side controller for the crossing request/grant handshake with the
// traffic-light state machine. It synchronizes and debounces the raw push
// button, raises and holds pedToggle until the traffic-light machine grants the
// pedestrian phase with a fresh rising edge on pedLight, then sequences the
// signal head: steady WALK, flashing DON'T WALK with a countdown, and back to
// steady DON'T WALK.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a button
//                    level change (1..15)
//   WALK_CYCLES      clock cycles of steady WALK (1..16)
//   FLASH_CYCLES     clock cycles of flashing DON'T WALK (1..16)
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   button     in   raw, asynchronous, bouncing push-button (1 = pressed)
//   pedLight   in   grant from the traffic-light machine, asynchronous
//   pedToggle  out  crossing request, held until granted
//   walk       out  WALK lamp
//   dontWalk   out  DON'T WALK lamp
//   waitLamp   out  "request registered" indicator on the button housing
//   countdown  out  remaining flash cycles, 0 outside FLASH
// -----------------------------------------------------------------------------
module ped_crossing_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WALK_CYCLES     = 8,
  parameter int unsigned FLASH_CYCLES    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       pedLight,
  output logic       pedToggle,
  output logic       walk,
  output logic       dontWalk,
  output logic       waitLamp,
  output logic [3:0] countdown
);

  // Terminal values of the 4-bit counters. The debounce counter accepts the
  // new level on the cycle it would have reached DEBOUNCE_CYCLES.
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] WALK_LAST  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WALK  = 2'd2,
    ST_FLASH = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic btn_meta_q;
  logic btn_s_q;
  logic ped_meta_q;
  logic ped_s_q;
  logic ped_prev_q;
  logic ped_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      ped_meta_q <= 1'b0;
      ped_s_q    <= 1'b0;
      ped_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= button;
      btn_s_q    <= btn_meta_q;
      ped_meta_q <= pedLight;
      ped_s_q    <= ped_meta_q;
      ped_prev_q <= ped_s_q;
    end
  end

  // Only a fresh edge grants; a level already high when REQ is entered does not.
  assign ped_rise = ped_s_q & ~ped_prev_q;

  // ---------------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------------
  logic       deb_level_q;
  logic       deb_level_d;
  logic       deb_prev_q;
  logic [3:0] deb_cnt_q;
  logic [3:0] deb_cnt_d;
  logic       press;

  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = 4'd0;
    if (btn_s_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = btn_s_q;
        deb_cnt_d   = 4'd0;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= 4'd0;
    end else begin
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_level_q;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  // One-cycle pulse in the cycle right after the debounced level goes high.
  assign press = deb_level_q & ~deb_prev_q;

  // ---------------------------------------------------------------------------
  // Crossing FSM, phase timers and pending flag
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [3:0] walk_tmr_q;
  logic [3:0] walk_tmr_d;
  logic [3:0] cd_q;
  logic [3:0] cd_d;
  logic       pending_q;
  logic       pending_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      walk_tmr_q <= 4'd0;
      cd_q       <= 4'd0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      walk_tmr_q <= walk_tmr_d;
      cd_q       <= cd_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_tmr_d = walk_tmr_q;
    cd_d       = 4'd0;          // countdown is held at 0 outside FLASH
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (press || pending_q) begin
          state_d   = ST_REQ;
          pending_d = 1'b0;
        end
      end

      ST_REQ: begin
        // A press here is already covered by the outstanding request.
        if (ped_rise) begin
          state_d    = ST_WALK;
          walk_tmr_d = WALK_LAST;
        end
      end

      ST_WALK: begin
        if (press) begin
          pending_d = 1'b1;
        end
        if (walk_tmr_q == 4'd0) begin
          state_d = ST_FLASH;
          cd_d    = FLASH_LAST;
        end else begin
          walk_tmr_d = walk_tmr_q - 4'd1;
        end
      end

      ST_FLASH: begin
        if (press) begin
          pending_d = 1'b1;
        end
        if (cd_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cd_d = cd_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    pedToggle = 1'b0;
    walk      = 1'b0;
    dontWalk  = 1'b1;
    waitLamp  = pending_q;
    case (state_q)
      ST_REQ: begin
        pedToggle = 1'b1;
        waitLamp  = 1'b1;
      end
      ST_WALK: begin
        walk     = 1'b1;
        dontWalk = 1'b0;
      end
      ST_FLASH: begin
        // Odd counts lit, even counts dark: gives the flashing head.
        dontWalk = cd_q[0];
      end
      default: begin
      end
    endcase
  end

  assign countdown = cd_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//
// Directed bench for ped_crossing_ctrl with default parameters
// (DEBOUNCE_CYCLES=4, WALK_CYCLES=8, FLASH_CYCLES=6). Inputs change 1 ns after
// a rising edge and outputs are sampled at that same point, so "edge N" means
// the value read just after the Nth rising edge following a stimulus change.
// -----------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

  logic       clk;
  logic       reset;
  logic       button;
  logic       pedLight;
  logic       pedToggle;
  logic       walk;
  logic       dontWalk;
  logic       waitLamp;
  logic [3:0] countdown;

  int n_checks;
  int n_errors;

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .WALK_CYCLES    (8),
    .FLASH_CYCLES   (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .pedLight (pedLight),
    .pedToggle(pedToggle),
    .walk     (walk),
    .dontWalk (dontWalk),
    .waitLamp (waitLamp),
    .countdown(countdown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("check %s: got %0d ok", tag, obs);
    end
  endtask

  initial begin
    int bad;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    button   = 1'b0;
    pedLight = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_pedToggle", 32'(pedToggle), 0);
    chk("rst_walk",      32'(walk),      0);
    chk("rst_dontWalk",  32'(dontWalk),  1);
    chk("rst_waitLamp",  32'(waitLamp),  0);
    chk("rst_countdown", 32'(countdown), 0);
    reset = 1'b0;
    repeat (2) tick();

    // ---------------- clean press: D+3 = 7 edges ----------------
    button = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) chk("press_e6_pedToggle", 32'(pedToggle), 0);
      if (e == 7) begin
        chk("press_e7_pedToggle", 32'(pedToggle), 1);
        chk("press_e7_waitLamp",  32'(waitLamp),  1);
        chk("press_e7_dontWalk",  32'(dontWalk),  1);
      end
    end
    button = 1'b0;

    // grant: walk on the third edge after pedLight rises
    pedLight = 1'b1;
    tick(); tick();
    chk("grant_e2_walk",      32'(walk),      0);
    chk("grant_e2_pedToggle", 32'(pedToggle), 1);
    tick();
    chk("grant_e3_walk",      32'(walk),      1);
    chk("grant_e3_pedToggle", 32'(pedToggle), 0);
    chk("grant_e3_dontWalk",  32'(dontWalk),  0);
    bad = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (walk !== 1'b1) bad++;
    end
    chk("walk_8_cycles", 32'(bad), 0);
    tick();
    chk("flash_walk_off",  32'(walk),      0);
    chk("flash_cd5",       32'(countdown), 5);
    chk("flash_cd5_dw",    32'(dontWalk),  1);
    for (int k = 4; k >= 0; k--) begin
      tick();
      chk("flash_cd",    32'(countdown), 32'(k));
      chk("flash_cd_dw", 32'(dontWalk),  32'(k % 2));
    end
    tick();
    chk("idle_dontWalk",  32'(dontWalk),  1);
    chk("idle_countdown", 32'(countdown), 0);
    chk("idle_pedToggle", 32'(pedToggle), 0);
    chk("idle_waitLamp",  32'(waitLamp),  0);
    pedLight = 1'b0;
    repeat (4) tick();

    // ---------------- bounce rejection ----------------
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      button = (i % 4 != 3);
      tick();
      if (pedToggle !== 1'b0) bad++;
    end
    chk("bounce_no_request", 32'(bad), 0);
    button = 1'b1;
    repeat (10) tick();
    chk("bounce_then_hold", 32'(pedToggle), 1);
    button = 1'b0;

    // complete this crossing but leave pedLight high afterwards (stale)
    pedLight = 1'b1;
    repeat (3) tick();
    chk("bounce_grant_walk", 32'(walk), 1);
    repeat (14) tick();
    chk("stale_pre_idle_walk", 32'(walk),      0);
    chk("stale_pre_idle_tog",  32'(pedToggle), 0);
    repeat (4) tick();

    // ---------------- stale grant ----------------
    button = 1'b1;
    repeat (7) tick();
    chk("stale_req", 32'(pedToggle), 1);
    button = 1'b0;
    repeat (20) tick();
    chk("stale_hold_walk", 32'(walk),      0);
    chk("stale_hold_tog",  32'(pedToggle), 1);
    pedLight = 1'b0;
    repeat (4) tick();
    chk("stale_low_walk", 32'(walk), 0);
    pedLight = 1'b1;
    tick(); tick();
    chk("stale_e2_walk", 32'(walk), 0);
    tick();
    chk("stale_grant_walk", 32'(walk), 1);

    // ---------------- pending: press lands on the last FLASH cycle ----------------
    repeat (7) tick();
    chk("walk_last_cycle", 32'(walk), 1);
    button = 1'b1;
    repeat (5) tick();
    chk("pend_cd1",      32'(countdown), 1);
    chk("pend_cd1_wait", 32'(waitLamp),  0);
    tick();
    chk("pend_cd0",      32'(countdown), 0);
    chk("pend_cd0_wait", 32'(waitLamp),  0);
    tick();
    chk("pend_idle_wait", 32'(waitLamp),  1);
    chk("pend_idle_tog",  32'(pedToggle), 0);
    chk("pend_idle_dw",   32'(dontWalk),  1);
    tick();
    chk("pend_req_tog",  32'(pedToggle), 1);
    chk("pend_req_wait", 32'(waitLamp),  1);
    button   = 1'b0;
    pedLight = 1'b0;

    // ---------------- held request ----------------
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pedToggle !== 1'b1 || waitLamp !== 1'b1 || walk !== 1'b0) bad++;
    end
    chk("held_100_cycles", 32'(bad), 0);

    // asynchronous reset in REQ drops the request without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_req_tog",  32'(pedToggle), 0);
    chk("rst_req_wait", 32'(waitLamp),  0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_req", 32'(pedToggle), 0);

    // ---------------- reset mid-WALK ----------------
    button = 1'b1;
    repeat (7) tick();
    chk("rewalk_req", 32'(pedToggle), 1);
    button   = 1'b0;
    pedLight = 1'b1;
    repeat (3) tick();
    chk("rewalk_walk", 32'(walk), 1);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_walk_walk", 32'(walk),      0);
    chk("rst_walk_dw",   32'(dontWalk),  1);
    chk("rst_walk_cd",   32'(countdown), 0);
    chk("rst_walk_tog",  32'(pedToggle), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
